// File: rtl/dpram_rr_arbiter.sv
// dpram_rr_arbiter: shares one registered-read dual-port SRAM between NUM_REQ
// requesters using independent round-robin arbiters for the write and read
// ports. Read data returns one cycle after the grant, tagged with the owner.
// Optional build macro DPRAM_ARB_WR_BYPASS_EN: on a same-cycle, same-address
// read/write collision the response carries the new write data (write-first)
// instead of the old SRAM contents (read-before-write, the default).
module dpram_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        wr_req,
    input  logic [NUM_REQ*ADDR_W-1:0] wr_addr,
    input  logic [NUM_REQ*DATA_W-1:0] wr_data,
    output logic [NUM_REQ-1:0]        wr_gnt,
    input  logic [NUM_REQ-1:0]        rd_req,
    input  logic [NUM_REQ*ADDR_W-1:0] rd_addr,
    output logic [NUM_REQ-1:0]        rd_gnt,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      mem_wen,
    output logic [ADDR_W-1:0]         mem_waddr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_ren,
    output logic [ADDR_W-1:0]         mem_raddr,
    input  logic [DATA_W-1:0]         mem_rdata
);

    typedef logic [ID_W-1:0] id_t;

    // First asserted request at or after ptr, wrapping; result is {hit, index}.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input id_t ptr);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!res[ID_W] && req[idx]) begin
                res = {1'b1, id_t'(idx)};
            end
        end
        return res;
    endfunction

    // Pointer moves just past the granted requester, wrapping at NUM_REQ-1.
    function automatic id_t ptr_after(input id_t k);
        id_t nxt;
        if (int'(k) == NUM_REQ - 1) begin
            nxt = '0;
        end else begin
            nxt = k + id_t'(1);
        end
        return nxt;
    endfunction

    id_t           wr_ptr;
    id_t           rd_ptr;
    logic [ID_W:0] wr_pick;
    logic [ID_W:0] rd_pick;
    logic          wr_hit;
    logic          rd_hit;
    id_t           wr_idx;
    id_t           rd_idx;

    // ---- stage p0: arbitration and SRAM access in the request cycle ----
    assign wr_pick = rr_pick(wr_req, wr_ptr);
    assign rd_pick = rr_pick(rd_req, rd_ptr);
    assign wr_hit  = wr_pick[ID_W] & ~rst;
    assign rd_hit  = rd_pick[ID_W] & ~rst;
    assign wr_idx  = wr_pick[ID_W-1:0];
    assign rd_idx  = rd_pick[ID_W-1:0];
    assign mem_wen = wr_hit;
    assign mem_ren = rd_hit;

    // Write grant decode and mux of the granted requester's address/data.
    always_comb begin
        wr_gnt    = '0;
        mem_waddr = '0;
        mem_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (wr_hit && int'(wr_idx) == i) begin
                wr_gnt[i] = 1'b1;
                mem_waddr = wr_addr[i*ADDR_W +: ADDR_W];
                mem_wdata = wr_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Read grant decode and mux of the granted requester's address.
    always_comb begin
        rd_gnt    = '0;
        mem_raddr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rd_hit && int'(rd_idx) == i) begin
                rd_gnt[i] = 1'b1;
                mem_raddr = rd_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Write round-robin pointer; holds when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (wr_hit) begin
            wr_ptr <= ptr_after(wr_idx);
        end
    end

    // Read round-robin pointer; holds when nothing is granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
        end else if (rd_hit) begin
            rd_ptr <= ptr_after(rd_idx);
        end
    end

    // ---- stage p1: response aligned with the SRAM's registered read ----
    logic vld_p1;
    id_t  id_p1;

    // Response valid/tag follow the read grant by exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            id_p1  <= '0;
        end else begin
            vld_p1 <= rd_hit;
            if (rd_hit) begin
                id_p1 <= rd_idx;
            end
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_id    = id_p1;

`ifdef DPRAM_ARB_WR_BYPASS_EN
    logic              byp_p0;
    logic              byp_p1;
    logic [DATA_W-1:0] byp_data_p1;

    assign byp_p0 = wr_hit & rd_hit & (mem_waddr == mem_raddr);

    // Collision flag: the response must carry the data written this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            byp_p1 <= 1'b0;
        end else begin
            byp_p1 <= byp_p0;
        end
    end

    // Capture the write data that a colliding read must return.
    always_ff @(posedge clk) begin
        byp_data_p1 <= mem_wdata;
    end

    assign rsp_data = byp_p1 ? byp_data_p1 : mem_rdata;
`else
    assign rsp_data = mem_rdata;
`endif

endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// Self-checking bench for dpram_rr_arbiter: directed scenarios followed by
// randomized traffic, all checked against a priority-queue reference model
// and a plain array image of memory contents.
module tb_dpram_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    wr_req, rd_req, wr_gnt, rd_gnt;
    logic [N*AW-1:0] wr_addr, rd_addr;
    logic [N*DW-1:0] wr_data;
    logic            rsp_valid;
    logic [IW-1:0]   rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            mem_wen, mem_ren;
    logic [AW-1:0]   mem_waddr, mem_raddr;
    logic [DW-1:0]   mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [N-1:0] gw, gr;

    dpram_rr_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Stand-in for the dual_port_sram macro: registered read, old data on collision.
    logic [DW-1:0] sram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_wen) sram[mem_waddr] <= mem_wdata;
        if (mem_ren) mem_rdata <= sram[mem_raddr];
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: each port keeps its requesters in current priority order;
    // the first requesting entry wins and the order restarts just after it.
    int            wq[$];
    int            rq[$];
    logic [DW-1:0] ref_mem [int];
    bit            e_vld = 1'b0;
    int            e_id  = 0;
    logic [DW-1:0] e_data = '0;

    always @(negedge clk) begin : model_b
        int            wk, rk;
        logic [N-1:0]  ewg, erg;
        logic [AW-1:0] ra, wa;
        wk = -1;
        rk = -1;
        if (!rst) begin
            foreach (wq[j]) if (wk < 0 && wr_req[wq[j]]) wk = wq[j];
            foreach (rq[j]) if (rk < 0 && rd_req[rq[j]]) rk = rq[j];
        end
        ewg = '0;
        erg = '0;
        if (wk >= 0) ewg[wk] = 1'b1;
        if (rk >= 0) erg[rk] = 1'b1;
        chk("wr_gnt", wr_gnt, ewg);
        chk("rd_gnt", rd_gnt, erg);
        chk("mem_wen", mem_wen, wk >= 0);
        chk("mem_ren", mem_ren, rk >= 0);
        if (wk >= 0) begin
            chk("mem_waddr", mem_waddr, wr_addr[wk*AW +: AW]);
            chk("mem_wdata", mem_wdata, wr_data[wk*DW +: DW]);
        end
        if (rk >= 0) chk("mem_raddr", mem_raddr, rd_addr[rk*AW +: AW]);
        chk("rsp_valid", rsp_valid, e_vld);
        if (e_vld) begin
            chk("rsp_id", rsp_id, e_id);
            chk("rsp_data", rsp_data, e_data);
        end
        if (rst) begin
            e_vld = 1'b0;
            wq.delete();
            rq.delete();
            for (int j = 0; j < N; j++) begin
                wq.push_back(j);
                rq.push_back(j);
            end
        end else begin
            e_vld = (rk >= 0);
            if (rk >= 0) begin
                ra     = rd_addr[rk*AW +: AW];
                e_id   = rk;
                e_data = ref_mem.exists(int'(ra)) ? ref_mem[int'(ra)] : '0;
`ifdef DPRAM_ARB_WR_BYPASS_EN
                if (wk >= 0 && wr_addr[wk*AW +: AW] == ra) e_data = wr_data[wk*DW +: DW];
`endif
                rq.delete();
                for (int j = 1; j <= N; j++) rq.push_back((rk + j) % N);
            end
            if (wk >= 0) begin
                wa = wr_addr[wk*AW +: AW];
                ref_mem[int'(wa)] = wr_data[wk*DW +: DW];
                wq.delete();
                for (int j = 1; j <= N; j++) wq.push_back((wk + j) % N);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) cyc();
        rst = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        if ($urandom_range(0, 7) == 0) a = '1;
        else a = AW'($urandom_range(0, 7));
        return a;
    endfunction

    initial begin
        for (int i = 0; i < (1 << AW); i++) sram[i] = '0;
        for (int j = 0; j < N; j++) begin
            wq.push_back(j);
            rq.push_back(j);
        end
        rst = 1'b1;
        wr_req = '0; rd_req = '0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;

        // Reset then idle
        repeat (2) begin
            @(negedge clk);
            chk("t1_rsp_valid", rsp_valid, 0);
            chk("t1_rsp_id", rsp_id, 0);
            chk("t1_mem_wen", mem_wen, 0);
            chk("t1_mem_ren", mem_ren, 0);
            cyc();
        end
        rst = 1'b0;

        // Single write then read
        wr_req = 4'b0001; wr_addr[0 +: AW] = 10'h005; wr_data[0 +: DW] = 32'hDEADBEEF;
        @(negedge clk); chk("t2_wr_gnt", wr_gnt, 4'b0001);
        cyc();
        wr_req = '0; rd_req = 4'b0001; rd_addr[0 +: AW] = 10'h005;
        @(negedge clk); chk("t2_rd_gnt", rd_gnt, 4'b0001);
        cyc();
        rd_req = '0;
        @(negedge clk);
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rsp_id", rsp_id, 0);
        chk("t2_rsp_data", rsp_data, 32'hDEADBEEF);
        cyc();

        // Round-robin fairness from pointer 0
        do_reset(2);
        rd_req = 4'b1111;
        for (int i = 0; i < N; i++) rd_addr[i*AW +: AW] = AW'(i + 1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("t3_rd_gnt", rd_gnt, 4'b0001 << (c % 4));
            if (c > 0) chk("t3_rsp_id", rsp_id, (c - 1) % 4);
            cyc();
        end
        rd_req = '0;
        @(negedge clk); chk("t3_rsp_id_last", rsp_id, 3);
        cyc();

        // Pointer skip and wrap: move rd_ptr to 2, then only req1/req3
        rd_req = 4'b0010;
        @(negedge clk); chk("t4_setup", rd_gnt, 4'b0010);
        cyc();
        rd_req = 4'b1010;
        @(negedge clk); chk("t4_skip", rd_gnt, 4'b1000);
        cyc();
        @(negedge clk); chk("t4_wrap", rd_gnt, 4'b0010);
        cyc();
        @(negedge clk); chk("t4_again", rd_gnt, 4'b1000);
        cyc();
        rd_req = '0;

        // Collision at 0x3FF
        wr_req = 4'b0001; wr_addr[0 +: AW] = 10'h3FF; wr_data[0 +: DW] = 32'h11111111;
        @(negedge clk); chk("t5_preload", wr_gnt, 4'b0001);
        cyc();
        wr_req = 4'b0100; wr_addr[2*AW +: AW] = 10'h3FF; wr_data[2*DW +: DW] = 32'h22222222;
        rd_req = 4'b0010; rd_addr[1*AW +: AW] = 10'h3FF;
        @(negedge clk);
        chk("t5_wr_gnt", wr_gnt, 4'b0100);
        chk("t5_rd_gnt", rd_gnt, 4'b0010);
        cyc();
        wr_req = '0; rd_req = '0;
`ifdef DPRAM_ARB_WR_BYPASS_EN
        @(negedge clk); chk("t5_collide", rsp_data, 32'h22222222);
`else
        @(negedge clk); chk("t5_collide", rsp_data, 32'h11111111);
`endif
        cyc();
        rd_req = 4'b0010;
        @(negedge clk); chk("t5_reread_gnt", rd_gnt, 4'b0010);
        cyc();
        rd_req = '0;
        @(negedge clk); chk("t5_reread", rsp_data, 32'h22222222);
        cyc();

        // Reset in the cycle a read would be granted
        rd_req = 4'b1111; wr_req = 4'b1111; rst = 1'b1;
        @(negedge clk);
        chk("t6_rd_gnt", rd_gnt, 0);
        chk("t6_wr_gnt", wr_gnt, 0);
        chk("t6_mem_ren", mem_ren, 0);
        chk("t6_mem_wen", mem_wen, 0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_rd_ptr0", rd_gnt, 4'b0001);
        chk("t6_wr_ptr0", wr_gnt, 4'b0001);
        cyc();
        wr_req = '0; rd_req = '0;

        // Randomized traffic; requests are held until granted
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            gw = wr_gnt;
            gr = rd_gnt;
            cyc();
            for (int i = 0; i < N; i++) begin
                if (gw[i] || !wr_req[i]) begin
                    wr_req[i] = ($urandom_range(0, 99) < 55);
                    wr_addr[i*AW +: AW] = rand_addr();
                    wr_data[i*DW +: DW] = $urandom();
                end
                if (gr[i] || !rd_req[i]) begin
                    rd_req[i] = ($urandom_range(0, 99) < 55);
                    rd_addr[i*AW +: AW] = rand_addr();
                end
            end
            rst = ($urandom_range(0, 149) == 0);
        end
        rst = 1'b0;
        wr_req = '0; rd_req = '0;
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dpram_rr_arbiter.md
Name: dpram_rr_arbiter

Overview:
- Shares one dual_port_sram instance (1024 x 32, registered read, separate read/write strobes) between NUM_REQ requesters.
- Two independent round-robin arbiters: one owns the write port, one owns the read port. Each port serves one request per cycle.
- Read data returns through a tagged, one-cycle response pipeline aligned to the SRAM read latency.
- Sits between fabric-side user logic and the dpram/dual_port_sram macro in the BRAM tech-mapping flow.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 10, SRAM address width.
- DATA_W, 32, SRAM data width.
- ID_W, 2, response tag width; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  single clock for arbiter and SRAM.
- rst  in  1  synchronous active-high reset.
- wr_req  in  NUM_REQ  per-requester write request; held until granted.
- wr_addr  in  NUM_REQ*ADDR_W  packed write addresses; requester i occupies slice i.
- wr_data  in  NUM_REQ*DATA_W  packed write data.
- wr_gnt  out  NUM_REQ  one-hot write grant; combinational.
- rd_req  in  NUM_REQ  per-requester read request.
- rd_addr  in  NUM_REQ*ADDR_W  packed read addresses.
- rd_gnt  out  NUM_REQ  one-hot read grant; combinational.
- rsp_valid  out  1  read data valid.
- rsp_id  out  ID_W  index of the requester that owns rsp_data.
- rsp_data  out  DATA_W  read data.
- mem_wen  out  1  to SRAM wen.
- mem_waddr  out  ADDR_W  to SRAM waddr.
- mem_wdata  out  DATA_W  to SRAM data_in.
- mem_ren  out  1  to SRAM ren.
- mem_raddr  out  ADDR_W  to SRAM raddr.
- mem_rdata  in  DATA_W  from SRAM d_out.

Behaviour:
- Reset state:
  - wr_ptr = 0, rd_ptr = 0.
  - rsp_valid = 0, rsp_id = 0.
  - While rst = 1: wr_gnt, rd_gnt, mem_wen and mem_ren are forced to 0. No SRAM access occurs in a reset cycle.
  - Reset mid-operation drops any pending response: rsp_valid is 0 in the cycle after rst is seen.
- Write arbiter:
  - Scans wr_req starting at index wr_ptr, wrapping modulo NUM_REQ. The first asserted bit gets wr_gnt.
  - mem_wen = |wr_gnt. mem_waddr and mem_wdata are muxed from the granted slice in the same cycle, so the write commits at that clock edge.
  - On a grant to requester k: wr_ptr <= (k+1) mod NUM_REQ. With no grant, wr_ptr holds.
- Read arbiter:
  - Same scheme on rd_req, rd_ptr, rd_gnt, mem_ren, mem_raddr.
  - Fully independent of the write arbiter: one write and one read may be granted in the same cycle.
- Response pipeline:
  - Read grant in cycle T to requester k gives rsp_valid = 1, rsp_id = k, rsp_data = mem_rdata in cycle T+1.
  - rsp_valid is 0 in any cycle that follows a cycle with no read grant.
  - Back-to-back read grants produce back-to-back responses. There is no backpressure; requesters must accept rsp in the cycle it is presented.
- Requester rules:
  - A requester deasserts req in the cycle after it sees gnt, or keeps it asserted to issue the next access.
  - Holding req continuously with other requesters active yields one grant every NUM_REQ cycles on that port (fairness bound).
- Pointer wrap: a grant to index NUM_REQ-1 sets the pointer to 0.
- Collision (read and write granted to the same address in the same cycle): without the optional feature, rsp_data returns the OLD contents (read-before-write).
- Unused requester slices are don't-care when their req bit is 0.

Optional Feature:
- Macro: DPRAM_ARB_WR_BYPASS_EN.
- Defined:
  - On a same-cycle, same-address read/write collision, register a bypass flag and the write data.
  - In T+1, rsp_data = the registered write data instead of mem_rdata (write-first semantics).
  - Bypass flag resets to 0.
- Undefined: no bypass logic is built; read-before-write as described in Behaviour.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, all req=0. Required: rsp_valid=0, mem_wen=0, mem_ren=0 throughout.
2. Single write then read: req0 writes addr 0x005 data 0xDEADBEEF; next cycle req0 reads 0x005. Required: rd_gnt=0001, then one cycle later rsp_valid=1, rsp_id=0, rsp_data=0xDEADBEEF.
3. Round-robin fairness: all four rd_req held high for 8 cycles. Required: rd_gnt sequence 0001,0010,0100,1000,0001,... and rsp_id sequence 0,1,2,3,0,... lagging by one cycle.
4. Pointer skip and wrap: rd_ptr=2, only req1 and req3 active. Required: req3 granted, then req1; rd_ptr goes 2→0→2.
5. Collision: addr 0x3FF preloaded 0x11111111; same cycle, req2 writes 0x22222222 and req1 reads 0x3FF. Required: rsp_data=0x11111111 without the macro, 0x22222222 with DPRAM_ARB_WR_BYPASS_EN; the following read returns 0x22222222 in both builds.
6. Reset mid-read: read granted in cycle T, rst=1 in cycle T. Required: no grant issued, rsp_valid=0 at T+1, wr_ptr=rd_ptr=0 afterwards.
